// File: rtl/matmul.sv
// 4x4 output-stationary systolic multiply, C = A x B on 32-bit elements (mod 2^32).
// A flows right, B flows down; accumulated rows are returned once per start.
module matmul (
  input  logic         clk,
  input  logic         rst,
  input  logic         input_start,
  input  logic [3:0]   counter,
  input  logic [127:0] inA_flat,
  input  logic [127:0] inB_flat,
  output logic [127:0] outD_flat,
  output logic         output_rdy
);

  logic [31:0] a_q   [4][4];
  logic [31:0] b_q   [4][4];
  logic [31:0] acc_q [4][4];
  logic [31:0] a_in  [4][4];
  logic [31:0] b_in  [4][4];
  logic        done;
  logic        out_win;
  logic [127:0] row_sel;

  for (genvar i = 0; i < 4; i++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_in[i][j] = inA_flat[127-32*i -: 32];
      end else begin : g_a_int
        assign a_in[i][j] = a_q[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in[i][j] = inB_flat[127-32*j -: 32];
      end else begin : g_b_int
        assign b_in[i][j] = b_q[i-1][j];
      end
    end
  end

  // Rows leave at counter 11..14; done suppresses a second burst after counter wrap.
  always_comb begin
    out_win = !done && (counter >= 4'd11) && (counter <= 4'd14);
    row_sel = '0;
    case (counter)
      4'd11:   row_sel = {acc_q[0][0], acc_q[0][1], acc_q[0][2], acc_q[0][3]};
      4'd12:   row_sel = {acc_q[1][0], acc_q[1][1], acc_q[1][2], acc_q[1][3]};
      4'd13:   row_sel = {acc_q[2][0], acc_q[2][1], acc_q[2][2], acc_q[2][3]};
      4'd14:   row_sel = {acc_q[3][0], acc_q[3][1], acc_q[3][2], acc_q[3][3]};
      default: row_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) begin
        for (int unsigned j = 0; j < 4; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
      done       <= 1'b0;
      outD_flat  <= '0;
      output_rdy <= 1'b0;
    end else if (input_start) begin
      for (int unsigned i = 0; i < 4; i++) begin
        for (int unsigned j = 0; j < 4; j++) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          acc_q[i][j] <= '0;
        end
      end
      done       <= 1'b0;
      output_rdy <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        for (int unsigned j = 0; j < 4; j++) begin
          acc_q[i][j] <= acc_q[i][j] + a_in[i][j] * b_in[i][j];
          a_q[i][j]   <= a_in[i][j];
          b_q[i][j]   <= b_in[i][j];
        end
      end
      output_rdy <= out_win;
      if (out_win) begin
        outD_flat <= row_sel;
        if (counter == 4'd14) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matmul.sv
// Directed bench for matmul: drives skewed wavefronts and checks returned rows.
module tb_matmul;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         input_start = 1'b0;
  logic [3:0]   counter = '0;
  logic [127:0] inA_flat = '0;
  logic [127:0] inB_flat = '0;
  logic [127:0] outD_flat;
  logic         output_rdy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0]  ma [4][4];
  logic [31:0]  mb [4][4];
  logic [127:0] exp_rows [4];
  logic [127:0] got [8];
  int           n_rdy;
  int           first_c;

  always #5 clk = ~clk;

  matmul dut (
    .clk(clk), .rst(rst), .input_start(input_start), .counter(counter),
    .inA_flat(inA_flat), .inB_flat(inB_flat),
    .outD_flat(outD_flat), .output_rdy(output_rdy)
  );

  function automatic logic [127:0] lanes_a(int c);
    logic [127:0] v = '0;
    int k;
    for (int i = 0; i < 4; i++) begin
      k = i + 4 - c;
      if (k >= 0 && k <= 3) v[127-32*i -: 32] = ma[i][k];
    end
    return v;
  endfunction

  function automatic logic [127:0] lanes_b(int c);
    logic [127:0] v = '0;
    int k;
    for (int j = 0; j < 4; j++) begin
      k = j + 4 - c;
      if (k >= 0 && k <= 3) v[127-32*j -: 32] = mb[k][j];
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mats();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = '0;
        mb[i][j] = '0;
      end
  endtask

  task automatic set_ref();
    ma[0] = '{32'd1, 32'd2, 32'd3, 32'd4};
    ma[1] = '{32'd5, 32'd6, 32'd7, 32'd8};
    ma[2] = '{32'd9, 32'd10, 32'd11, 32'd12};
    ma[3] = '{32'd13, 32'd14, 32'd15, 32'd16};
    mb[0] = '{32'd2, 32'd7, 32'd9, 32'd0};
    mb[1] = '{32'd0, 32'd2, 32'd0, 32'd82};
    mb[2] = '{32'd4, 32'd0, 32'd2, 32'd0};
    mb[3] = '{32'd0, 32'd0, 32'd0, 32'd1};
  endtask

  task automatic set_ident();
    set_ref();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        ma[i][j] = (i == j) ? 32'd1 : 32'd0;
  endtask

  task automatic set_b_rows();
    exp_rows[0] = {32'd2, 32'd7, 32'd9, 32'd0};
    exp_rows[1] = {32'd0, 32'd2, 32'd0, 32'd82};
    exp_rows[2] = {32'd4, 32'd0, 32'd2, 32'd0};
    exp_rows[3] = {32'd0, 32'd0, 32'd0, 32'd1};
  endtask

  task automatic do_start(int n);
    input_start = 1'b1;
    counter = '0;
    inA_flat = '0;
    inB_flat = '0;
    repeat (n) tick();
    input_start = 1'b0;
  endtask

  task automatic run_seq(int c0, int c1);
    for (int c = c0; c <= c1; c++) begin
      counter = 4'(c % 16);
      inA_flat = lanes_a(c);
      inB_flat = lanes_b(c);
      tick();
      if (output_rdy) begin
        if (n_rdy == 0) first_c = c;
        if (n_rdy < 8) got[n_rdy] = outD_flat;
        n_rdy++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int n = 0; n < 2; n++) begin
      inA_flat = {$urandom, $urandom, $urandom, $urandom};
      inB_flat = {$urandom, $urandom, $urandom, $urandom};
      counter = 4'($urandom_range(0, 15));
      input_start = 1'($urandom_range(0, 1));
      tick();
      tests_run++;
      if (output_rdy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_rdy cycle %0d: got %b expected 0", n, output_rdy);
      end
      tests_run++;
      if (outD_flat !== 128'd0) begin
        tests_failed++;
        $display("FAIL reset_outD cycle %0d: got %h expected 0", n, outD_flat);
      end
    end
    input_start = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_reference();
    clear_mats();
    set_ref();
    exp_rows[0] = {32'd14, 32'd11, 32'd15, 32'd168};
    exp_rows[1] = {32'd38, 32'd47, 32'd59, 32'd500};
    exp_rows[2] = {32'd62, 32'd83, 32'd103, 32'd832};
    exp_rows[3] = {32'd86, 32'd119, 32'd147, 32'd1164};
    do_start(2);
    n_rdy = 0; first_c = -1;
    run_seq(1, 15);
    tests_run++;
    if (n_rdy !== 4) begin
      tests_failed++;
      $display("FAIL ref_rdy_width: got %0d cycles expected 4", n_rdy);
    end
    tests_run++;
    if (first_c !== 11) begin
      tests_failed++;
      $display("FAIL ref_first_row_counter: got %0d expected 11", first_c);
    end
    for (int r = 0; r < 4; r++) begin
      tests_run++;
      if (got[r] !== exp_rows[r]) begin
        tests_failed++;
        $display("FAIL ref_row%0d: got %h expected %h", r, got[r], exp_rows[r]);
      end
    end
    tests_run++;
    if (output_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ref_rdy_after_burst: got %b expected 0", output_rdy);
    end
    tests_run++;
    if (outD_flat !== exp_rows[3]) begin
      tests_failed++;
      $display("FAIL ref_outD_hold: got %h expected %h", outD_flat, exp_rows[3]);
    end
  endtask

  task automatic test_identity();
    clear_mats();
    set_ident();
    set_b_rows();
    do_start(1);
    n_rdy = 0; first_c = -1;
    run_seq(1, 15);
    tests_run++;
    if (n_rdy !== 4) begin
      tests_failed++;
      $display("FAIL ident_rdy_width: got %0d cycles expected 4", n_rdy);
    end
    for (int r = 0; r < 4; r++) begin
      tests_run++;
      if (got[r] !== exp_rows[r]) begin
        tests_failed++;
        $display("FAIL ident_row%0d: got %h expected %h", r, got[r], exp_rows[r]);
      end
    end
  endtask

  task automatic test_wrap();
    clear_mats();
    ma[0][0] = 32'hFFFF_FFFF;
    mb[0][0] = 32'd2;
    exp_rows[0] = {32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0};
    exp_rows[1] = '0;
    exp_rows[2] = '0;
    exp_rows[3] = '0;
    do_start(1);
    n_rdy = 0; first_c = -1;
    run_seq(1, 15);
    tests_run++;
    if (n_rdy !== 4) begin
      tests_failed++;
      $display("FAIL wrap_rdy_width: got %0d cycles expected 4", n_rdy);
    end
    for (int r = 0; r < 4; r++) begin
      tests_run++;
      if (got[r] !== exp_rows[r]) begin
        tests_failed++;
        $display("FAIL wrap_row%0d: got %h expected %h", r, got[r], exp_rows[r]);
      end
    end
  endtask

  task automatic test_restart();
    clear_mats();
    set_ref();
    do_start(1);
    n_rdy = 0; first_c = -1;
    run_seq(1, 6);
    set_ident();
    set_b_rows();
    do_start(3);
    run_seq(1, 15);
    tests_run++;
    if (n_rdy !== 4) begin
      tests_failed++;
      $display("FAIL restart_rdy_total: got %0d cycles expected 4", n_rdy);
    end
    tests_run++;
    if (first_c !== 11) begin
      tests_failed++;
      $display("FAIL restart_first_row_counter: got %0d expected 11", first_c);
    end
    for (int r = 0; r < 4; r++) begin
      tests_run++;
      if (got[r] !== exp_rows[r]) begin
        tests_failed++;
        $display("FAIL restart_row%0d: got %h expected %h", r, got[r], exp_rows[r]);
      end
    end
  endtask

  task automatic test_no_refire();
    clear_mats();
    n_rdy = 0; first_c = -1;
    run_seq(16, 37);
    tests_run++;
    if (n_rdy !== 0) begin
      tests_failed++;
      $display("FAIL no_refire: got %0d rdy cycles expected 0", n_rdy);
    end
  endtask

  task automatic test_reset_mid();
    clear_mats();
    set_ref();
    do_start(1);
    n_rdy = 0; first_c = -1;
    run_seq(1, 12);
    tests_run++;
    if (n_rdy !== 2 || got[1] !== {32'd38, 32'd47, 32'd59, 32'd500}) begin
      tests_failed++;
      $display("FAIL midreset_prefix: got %0d rows, row1 %h expected 2 rows, row1 %h",
               n_rdy, got[1], {32'd38, 32'd47, 32'd59, 32'd500});
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (output_rdy !== 1'b0 || outD_flat !== 128'd0) begin
      tests_failed++;
      $display("FAIL midreset_async: got rdy %b outD %h expected 0/0", output_rdy, outD_flat);
    end
    counter = 4'd13;
    tick();
    tests_run++;
    if (output_rdy !== 1'b0 || outD_flat !== 128'd0) begin
      tests_failed++;
      $display("FAIL midreset_held: got rdy %b outD %h expected 0/0", output_rdy, outD_flat);
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_reference();
    test_identity();
    test_wrap();
    test_restart();
    test_no_refire();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
